// File: rtl/coralnpu_axi_slave_mem_if.sv
// AXI4 signal bundle between a CoralNPU master port and coralnpu_axi_slave_mem.
interface coralnpu_axi_slave_mem_if #(
    parameter int unsigned AWIDTH  = 32,
    parameter int unsigned DWIDTH  = 128,
    parameter int unsigned IDWIDTH = 6
);
    logic                  awvalid;
    logic                  awready;
    logic [IDWIDTH-1:0]    awid;
    logic [AWIDTH-1:0]     awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awlock;
    logic [3:0]            awcache;
    logic [2:0]            awprot;
    logic [3:0]            awqos;
    logic [3:0]            awregion;
    logic                  wvalid;
    logic                  wready;
    logic [DWIDTH-1:0]     wdata;
    logic [DWIDTH/8-1:0]   wstrb;
    logic                  wlast;
    logic                  bvalid;
    logic                  bready;
    logic [IDWIDTH-1:0]    bid;
    logic [1:0]            bresp;
    logic                  arvalid;
    logic                  arready;
    logic [IDWIDTH-1:0]    arid;
    logic [AWIDTH-1:0]     araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic [3:0]            arqos;
    logic [3:0]            arregion;
    logic                  rvalid;
    logic                  rready;
    logic [IDWIDTH-1:0]    rid;
    logic [DWIDTH-1:0]     rdata;
    logic [1:0]            rresp;
    logic                  rlast;

    modport master (
        output awvalid, awid, awaddr, awlen, awsize, awburst,
               awlock, awcache, awprot, awqos, awregion,
               wvalid, wdata, wstrb, wlast, bready,
               arvalid, arid, araddr, arlen, arsize, arburst,
               arlock, arcache, arprot, arqos, arregion, rready,
        input  awready, wready, bvalid, bid, bresp,
               arready, rvalid, rid, rdata, rresp, rlast
    );

    modport slave (
        input  awvalid, awid, awaddr, awlen, awsize, awburst,
               awlock, awcache, awprot, awqos, awregion,
               wvalid, wdata, wstrb, wlast, bready,
               arvalid, arid, araddr, arlen, arsize, arburst,
               arlock, arcache, arprot, arqos, arregion, rready,
        output awready, wready, bvalid, bid, bresp,
               arready, rvalid, rid, rdata, rresp, rlast
    );
endinterface

// File: rtl/coralnpu_axi_slave_mem.sv
// AXI4 slave RAM with FIXED/INCR bursts, narrow sizes, byte strobes and SLVERR.
// WRAP bursts are legal only when CORALNPU_AXI_SLAVE_MEM_WRAP_EN is defined.
module coralnpu_axi_slave_mem #(
    parameter int unsigned       AWIDTH    = 32,
    parameter int unsigned       DWIDTH    = 128,
    parameter int unsigned       IDWIDTH   = 6,
    parameter int unsigned       DEPTH     = 1024,
    parameter logic [AWIDTH-1:0] BASE_ADDR = '0
) (
    input logic                     clk,
    input logic                     reset,
    coralnpu_axi_slave_mem_if.slave axi
);
    localparam int unsigned NB  = DWIDTH / 8;
    localparam int unsigned OFF = $clog2(NB);
    localparam int unsigned IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

    logic [DWIDTH-1:0] mem [DEPTH];

    function automatic logic legal(input logic [2:0] size, input logic [7:0] len,
                                   input logic [1:0] burst);
        logic ok;
        ok = (32'(size) <= OFF) && (burst != 2'b11);
        if (burst == 2'b10) begin
`ifdef CORALNPU_AXI_SLAVE_MEM_WRAP_EN
            ok = ok && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
`else
            ok = 1'b0;
`endif
        end
        return ok;
    endfunction

    function automatic logic in_range(input logic [AWIDTH-1:0] a);
        return (a >= BASE_ADDR) && (((a - BASE_ADDR) >> OFF) < AWIDTH'(DEPTH));
    endfunction

    function automatic logic [IW-1:0] word_idx(input logic [AWIDTH-1:0] a);
        logic [AWIDTH-1:0] w;
        w = (a - BASE_ADDR) >> OFF;
        return w[IW-1:0];
    endfunction

    // WRAP keeps the upper bits fixed and lets the step roll over inside the container.
    function automatic logic [AWIDTH-1:0] next_addr(input logic [AWIDTH-1:0] a,
                                                    input logic [7:0] len,
                                                    input logic [2:0] size,
                                                    input logic [1:0] burst);
        logic [AWIDTH-1:0] step, mask;
        step = AWIDTH'(1) << size;
        mask = ((AWIDTH'(len) + AWIDTH'(1)) << size) - AWIDTH'(1);
        case (burst)
            2'b01:   return a + step;
            2'b10:   return (a & ~mask) | ((a + step) & mask);
            default: return a;
        endcase
    endfunction

    wstate_t           w_state;
    logic [AWIDTH-1:0] w_addr;
    logic [IDWIDTH-1:0] w_id;
    logic [7:0]        w_len, w_beat;
    logic [2:0]        w_size;
    logic [1:0]        w_burst;
    logic              w_legal, w_err;

    logic w_fire_c, w_ok_c, w_last_c, w_bad_c, w_we_c;
    assign w_fire_c = (w_state == W_DATA) && axi.wvalid && axi.wready;
    assign w_ok_c   = w_legal && in_range(w_addr);
    assign w_last_c = (w_beat == w_len);
    assign w_bad_c  = !w_ok_c || (axi.wlast != w_last_c);
    assign w_we_c   = w_fire_c && w_ok_c;

    // Byte-lane writes; the RAM array itself carries no reset.
    always_ff @(posedge clk) begin
        if (w_we_c) begin
            for (int b = 0; b < int'(NB); b++) begin
                if (axi.wstrb[b]) mem[word_idx(w_addr)][b*8 +: 8] <= axi.wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state     <= W_IDLE;
            axi.awready <= 1'b0;
            axi.wready  <= 1'b0;
            axi.bvalid  <= 1'b0;
            axi.bid     <= '0;
            axi.bresp   <= RESP_OKAY;
            w_addr      <= '0;
            w_id        <= '0;
            w_len       <= '0;
            w_beat      <= '0;
            w_size      <= '0;
            w_burst     <= '0;
            w_legal     <= 1'b0;
            w_err       <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (axi.awready && axi.awvalid) begin
                        w_id        <= axi.awid;
                        w_addr      <= axi.awaddr;
                        w_len       <= axi.awlen;
                        w_size      <= axi.awsize;
                        w_burst     <= axi.awburst;
                        w_legal     <= legal(axi.awsize, axi.awlen, axi.awburst);
                        w_beat      <= '0;
                        w_err       <= 1'b0;
                        axi.awready <= 1'b0;
                        axi.wready  <= 1'b1;
                        w_state     <= W_DATA;
                    end else begin
                        axi.awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_fire_c) begin
                        if (w_bad_c) w_err <= 1'b1;
                        if (w_last_c) begin
                            axi.wready <= 1'b0;
                            axi.bvalid <= 1'b1;
                            axi.bid    <= w_id;
                            axi.bresp  <= (w_err || w_bad_c) ? RESP_SLVERR : RESP_OKAY;
                            w_state    <= W_RESP;
                        end else begin
                            w_beat <= w_beat + 8'd1;
                            w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
                        end
                    end
                end
                W_RESP: begin
                    if (axi.bready) begin
                        axi.bvalid  <= 1'b0;
                        axi.awready <= 1'b1;
                        w_state     <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    rstate_t           r_state;
    logic [AWIDTH-1:0] r_addr;
    logic [7:0]        r_len, r_beat;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;
    logic              r_legal;

    // Address of the beat being loaded: AR fields on acceptance, burst tracker afterwards.
    logic [AWIDTH-1:0] r_src_addr_c;
    logic              r_ok_c;
    logic [DWIDTH-1:0] r_word_c;
    always_comb begin
        r_src_addr_c = r_addr;
        r_ok_c       = r_legal && in_range(r_addr);
        if (r_state == R_IDLE) begin
            r_src_addr_c = axi.araddr;
            r_ok_c       = legal(axi.arsize, axi.arlen, axi.arburst) && in_range(axi.araddr);
        end
        r_word_c = r_ok_c ? mem[word_idx(r_src_addr_c)] : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= R_IDLE;
            axi.arready <= 1'b0;
            axi.rvalid  <= 1'b0;
            axi.rlast   <= 1'b0;
            axi.rid     <= '0;
            axi.rresp   <= RESP_OKAY;
            axi.rdata   <= '0;
            r_addr      <= '0;
            r_len       <= '0;
            r_beat      <= '0;
            r_size      <= '0;
            r_burst     <= '0;
            r_legal     <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (axi.arready && axi.arvalid) begin
                        axi.rid     <= axi.arid;
                        r_len       <= axi.arlen;
                        r_size      <= axi.arsize;
                        r_burst     <= axi.arburst;
                        r_legal     <= legal(axi.arsize, axi.arlen, axi.arburst);
                        r_addr      <= next_addr(axi.araddr, axi.arlen, axi.arsize, axi.arburst);
                        r_beat      <= 8'd1;
                        axi.rdata   <= r_word_c;
                        axi.rresp   <= r_ok_c ? RESP_OKAY : RESP_SLVERR;
                        axi.rlast   <= (axi.arlen == 8'd0);
                        axi.rvalid  <= 1'b1;
                        axi.arready <= 1'b0;
                        r_state     <= R_DATA;
                    end else begin
                        axi.arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (axi.rready) begin
                        if (axi.rlast) begin
                            axi.rvalid  <= 1'b0;
                            axi.rlast   <= 1'b0;
                            axi.arready <= 1'b1;
                            r_state     <= R_IDLE;
                        end else begin
                            axi.rdata <= r_word_c;
                            axi.rresp <= r_ok_c ? RESP_OKAY : RESP_SLVERR;
                            axi.rlast <= (r_beat == r_len);
                            r_beat    <= r_beat + 8'd1;
                            r_addr    <= next_addr(r_addr, r_len, r_size, r_burst);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_coralnpu_axi_slave_mem.sv
// Directed bench for coralnpu_axi_slave_mem: bursts, strobes, range errors, WRAP, wlast and reset.
module tb_coralnpu_axi_slave_mem;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    coralnpu_axi_slave_mem_if #(.AWIDTH(32), .DWIDTH(128), .IDWIDTH(6)) axi();

    coralnpu_axi_slave_mem #(
        .AWIDTH(32), .DWIDTH(128), .IDWIDTH(6), .DEPTH(1024), .BASE_ADDR(32'h0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .axi(axi)
    );

    int checks = 0;
    int errors = 0;

    logic [127:0] wr_data [16];
    logic [127:0] rd_data [16];
    logic [1:0]   rd_resp [16];
    logic         rd_last [16];
    logic [5:0]   rd_id   [16];
    int           rd_n, rd_wait, w_wait, b_wait;
    logic [1:0]   b_resp;
    logic [5:0]   b_id;

    task automatic init_inputs();
        axi.awvalid = 0; axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0;
        axi.awburst = '0; axi.awlock = 0; axi.awcache = '0; axi.awprot = '0; axi.awqos = '0;
        axi.awregion = '0; axi.wvalid = 0; axi.wdata = '0; axi.wstrb = '0; axi.wlast = 0;
        axi.bready = 0; axi.arvalid = 0; axi.arid = '0; axi.araddr = '0; axi.arlen = '0;
        axi.arsize = '0; axi.arburst = '0; axi.arlock = 0; axi.arcache = '0; axi.arprot = '0;
        axi.arqos = '0; axi.arregion = '0; axi.rready = 0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [5:0] id, input logic [15:0] strb,
                            input int last_beat);
        int n;
        @(negedge clk);
        axi.awvalid = 1; axi.awaddr = addr; axi.awlen = len; axi.awsize = size;
        axi.awburst = burst; axi.awid = id;
        n = 0;
        while (!axi.awready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin checks++; errors++; $display("FAIL aw_timeout got awready=0 want 1"); end
        @(negedge clk);
        axi.awvalid = 0;
        w_wait = 0;
        for (int b = 0; b <= int'(len); b++) begin
            axi.wvalid = 1; axi.wdata = wr_data[b]; axi.wstrb = strb; axi.wlast = (b == last_beat);
            n = 0;
            while (!axi.wready && n < 50) begin @(negedge clk); n++; w_wait++; end
            if (n >= 50) begin checks++; errors++; $display("FAIL w_timeout beat %0d got wready=0 want 1", b); end
            @(negedge clk);
        end
        axi.wvalid = 0; axi.wlast = 0; axi.bready = 1;
        b_wait = 0;
        while (!axi.bvalid && b_wait < 50) begin @(negedge clk); b_wait++; end
        if (b_wait >= 50) begin checks++; errors++; $display("FAIL b_timeout got bvalid=0 want 1"); end
        b_resp = axi.bresp; b_id = axi.bid;
        @(negedge clk);
        axi.bready = 0;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [5:0] id);
        int  n;
        logic done;
        @(negedge clk);
        axi.arvalid = 1; axi.araddr = addr; axi.arlen = len; axi.arsize = size;
        axi.arburst = burst; axi.arid = id;
        n = 0;
        while (!axi.arready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin checks++; errors++; $display("FAIL ar_timeout got arready=0 want 1"); end
        @(negedge clk);
        axi.arvalid = 0; axi.rready = 1;
        rd_n = 0; rd_wait = 0; n = 0; done = 0;
        while (!done && rd_n < 16 && n < 200) begin
            if (axi.rvalid) begin
                rd_data[rd_n] = axi.rdata; rd_resp[rd_n] = axi.rresp;
                rd_last[rd_n] = axi.rlast; rd_id[rd_n] = axi.rid;
                done = axi.rlast || (rd_n == int'(len));
                rd_n++;
            end else begin
                rd_wait++;
            end
            n++;
            @(negedge clk);
        end
        if (n >= 200) begin checks++; errors++; $display("FAIL r_timeout got %0d beats want %0d", rd_n, int'(len) + 1); end
        axi.rready = 0;
    endtask

    task automatic test_reset();
        init_inputs();
        reset = 1;
        repeat (3) @(negedge clk);
        checks++; if (axi.awready !== 1'b0) begin errors++; $display("FAIL rst_awready got %b want 0", axi.awready); end
        checks++; if (axi.wready !== 1'b0) begin errors++; $display("FAIL rst_wready got %b want 0", axi.wready); end
        checks++; if (axi.bvalid !== 1'b0) begin errors++; $display("FAIL rst_bvalid got %b want 0", axi.bvalid); end
        checks++; if (axi.arready !== 1'b0) begin errors++; $display("FAIL rst_arready got %b want 0", axi.arready); end
        checks++; if (axi.rvalid !== 1'b0 || axi.rlast !== 1'b0) begin errors++; $display("FAIL rst_rvalid_rlast got %b%b want 00", axi.rvalid, axi.rlast); end
        checks++; if (axi.rdata !== 128'h0 || axi.rresp !== 2'b00 || axi.bresp !== 2'b00 || axi.bid !== 6'h0 || axi.rid !== 6'h0) begin
            errors++; $display("FAIL rst_fields got rdata=%h rresp=%b bresp=%b want zeros", axi.rdata, axi.rresp, axi.bresp);
        end
        reset = 0;
        @(negedge clk);
        checks++; if (axi.awready !== 1'b1 || axi.arready !== 1'b1) begin
            errors++; $display("FAIL post_rst_ready got aw=%b ar=%b want 1 1", axi.awready, axi.arready);
        end
    endtask

    task automatic test_incr();
        for (int i = 0; i < 4; i++) wr_data[i] = 128'(i + 1);
        do_write(32'h40, 8'd3, 3'd4, 2'b01, 6'h05, 16'hFFFF, 3);
        checks++; if (b_resp !== 2'b00) begin errors++; $display("FAIL incr_bresp got %b want 00", b_resp); end
        checks++; if (b_id !== 6'h05) begin errors++; $display("FAIL incr_bid got %h want 05", b_id); end
        checks++; if (w_wait !== 0 || b_wait !== 0) begin errors++; $display("FAIL incr_w_latency got w_wait=%0d b_wait=%0d want 0 0", w_wait, b_wait); end
        checks++; if (axi.awready !== 1'b1) begin errors++; $display("FAIL incr_awready_after_b got %b want 1", axi.awready); end
        do_read(32'h40, 8'd3, 3'd4, 2'b01, 6'h09);
        checks++; if (rd_n !== 4) begin errors++; $display("FAIL incr_rbeats got %0d want 4", rd_n); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (rd_data[i] !== 128'(i + 1) || rd_resp[i] !== 2'b00 || rd_last[i] !== (i == 3) || rd_id[i] !== 6'h09) begin
                errors++; $display("FAIL incr_rbeat%0d got data=%h resp=%b last=%b id=%h want %h 00 %b 09",
                                   i, rd_data[i], rd_resp[i], rd_last[i], rd_id[i], i + 1, (i == 3));
            end
        end
        checks++; if (rd_wait !== 0) begin errors++; $display("FAIL incr_r_bubbles got %0d want 0", rd_wait); end
        checks++; if (axi.arready !== 1'b1) begin errors++; $display("FAIL incr_arready_after_r got %b want 1", axi.arready); end
    endtask

    task automatic test_strobe();
        wr_data[0] = '1;
        do_write(32'h100, 8'd0, 3'd4, 2'b01, 6'h01, 16'hFFFF, 0);
        wr_data[0] = 128'h11223344_55667788_99AABBCC_DDEEFF00;
        do_write(32'h100, 8'd0, 3'd4, 2'b01, 6'h01, 16'h000F, 0);
        checks++; if (b_resp !== 2'b00) begin errors++; $display("FAIL strobe_bresp got %b want 00", b_resp); end
        do_read(32'h100, 8'd0, 3'd4, 2'b01, 6'h01);
        checks++; if (rd_data[0] !== 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_DDEEFF00 || rd_resp[0] !== 2'b00) begin
            errors++; $display("FAIL strobe_rdata got %h resp=%b want ffffffffffffffffffffffffddeeff00 00", rd_data[0], rd_resp[0]);
        end
    endtask

    task automatic test_out_of_range();
        wr_data[0] = 128'hCAFE;
        do_write(32'h0, 8'd0, 3'd4, 2'b01, 6'h02, 16'hFFFF, 0);
        wr_data[0] = 128'hDEAD;
        do_write(32'h4000, 8'd0, 3'd4, 2'b01, 6'h03, 16'hFFFF, 0);
        checks++; if (b_resp !== 2'b10) begin errors++; $display("FAIL oor_bresp got %b want 10", b_resp); end
        do_read(32'h4000, 8'd0, 3'd4, 2'b01, 6'h03);
        checks++; if (rd_data[0] !== 128'h0 || rd_resp[0] !== 2'b10 || rd_last[0] !== 1'b1) begin
            errors++; $display("FAIL oor_read got data=%h resp=%b last=%b want 0 10 1", rd_data[0], rd_resp[0], rd_last[0]);
        end
        do_read(32'h0, 8'd0, 3'd4, 2'b01, 6'h03);
        checks++; if (rd_data[0] !== 128'hCAFE || rd_resp[0] !== 2'b00) begin
            errors++; $display("FAIL oor_mem_unchanged got %h resp=%b want cafe 00", rd_data[0], rd_resp[0]);
        end
    endtask

    task automatic test_wrap();
        logic [127:0] exp_d [4];
        logic [1:0]   exp_r;
        for (int i = 0; i < 4; i++) wr_data[i] = 128'(32'hA0 + i);
        do_write(32'h0, 8'd3, 3'd4, 2'b01, 6'h06, 16'hFFFF, 3);
`ifdef CORALNPU_AXI_SLAVE_MEM_WRAP_EN
        exp_d[0] = 128'hA3; exp_d[1] = 128'hA0; exp_d[2] = 128'hA1; exp_d[3] = 128'hA2; exp_r = 2'b00;
`else
        for (int i = 0; i < 4; i++) exp_d[i] = 128'h0;
        exp_r = 2'b10;
`endif
        do_read(32'h30, 8'd3, 3'd4, 2'b10, 6'h0A);
        checks++; if (rd_n !== 4) begin errors++; $display("FAIL wrap_rbeats got %0d want 4", rd_n); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (rd_data[i] !== exp_d[i] || rd_resp[i] !== exp_r || rd_last[i] !== (i == 3)) begin
                errors++; $display("FAIL wrap_rbeat%0d got data=%h resp=%b last=%b want %h %b %b",
                                   i, rd_data[i], rd_resp[i], rd_last[i], exp_d[i], exp_r, (i == 3));
            end
        end
    endtask

    task automatic test_wlast_err();
        for (int i = 0; i < 4; i++) wr_data[i] = 128'(32'h10 + i);
        do_write(32'h200, 8'd3, 3'd4, 2'b01, 6'h07, 16'hFFFF, 1);
        checks++; if (b_resp !== 2'b10 || b_id !== 6'h07) begin
            errors++; $display("FAIL wlast_bresp got resp=%b id=%h want 10 07", b_resp, b_id);
        end
        checks++; if (w_wait !== 0 || b_wait !== 0) begin
            errors++; $display("FAIL wlast_all_beats got w_wait=%0d b_wait=%0d want 0 0", w_wait, b_wait);
        end
    endtask

    task automatic test_reset_mid_read();
        int n, beats;
        @(negedge clk);
        axi.arvalid = 1; axi.araddr = 32'h40; axi.arlen = 8'd7; axi.arsize = 3'd4;
        axi.arburst = 2'b01; axi.arid = 6'h0B;
        n = 0;
        while (!axi.arready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        axi.arvalid = 0; axi.rready = 1;
        beats = 0; n = 0;
        while (beats < 2 && n < 50) begin
            if (axi.rvalid) beats++;
            n++;
            @(negedge clk);
        end
        checks++; if (axi.rvalid !== 1'b1 || beats !== 2) begin
            errors++; $display("FAIL midrd_beat2 got rvalid=%b beats=%0d want 1 2", axi.rvalid, beats);
        end
        reset = 1;
        #1;
        checks++; if (axi.rvalid !== 1'b0 || axi.rlast !== 1'b0 || axi.arready !== 1'b0) begin
            errors++; $display("FAIL midrd_async got rvalid=%b rlast=%b arready=%b want 0 0 0", axi.rvalid, axi.rlast, axi.arready);
        end
        @(negedge clk);
        axi.rready = 0;
        reset = 0;
        @(negedge clk);
        checks++; if (axi.arready !== 1'b1 || axi.rvalid !== 1'b0 || axi.bvalid !== 1'b0) begin
            errors++; $display("FAIL midrd_recover got arready=%b rvalid=%b bvalid=%b want 1 0 0", axi.arready, axi.rvalid, axi.bvalid);
        end
        do_read(32'h40, 8'd3, 3'd4, 2'b01, 6'h0C);
        for (int i = 0; i < 4; i++) begin
            checks++; if (rd_data[i] !== 128'(i + 1) || rd_resp[i] !== 2'b00) begin
                errors++; $display("FAIL midrd_reread%0d got %h resp=%b want %h 00", i, rd_data[i], rd_resp[i], i + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_incr();
        test_strobe();
        test_out_of_range();
        test_wrap();
        test_wlast_err();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
